// File: rtl/des_sbox_engine.sv
// DES S-box substitution engine: LANES S-boxes per cycle over 8/LANES cycles,
// with optional DES P permutation on the assembled 32-bit word.
module des_sbox_engine #(
  parameter int unsigned LANES   = 2,
  parameter bit          PERM_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [47:0] i_din,
  input  logic        i_perm,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_dout,
  output logic        o_busy
);

  localparam int unsigned N  = 8 / LANES;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = LANES * 6;

  // One 256-bit word per S-box: row 0 first, 16 nibbles per row, column 0 leftmost.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  localparam int unsigned PTAB [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };

  typedef enum logic [1:0] {StIdle, StSub, StHold} state_e;

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
    logic [5:0] entry;
    entry = {b[5], b[0], b[4:1]};
    return SBOX[box][255 - 4 * int'(entry) -: 4];
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int k = 0; k < 32; k++) begin
      y[31 - k] = x[32 - PTAB[k]];
    end
    return y;
  endfunction

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [47:0]   sreg_q;
  logic          perm_q;
  logic [31:0]   dout_q;
  logic          out_valid_q;
  logic          busy_q;

  logic [31:0]   sub_word;
  logic [31:0]   result;
  logic [2:0]    box;
  logic          last;

  // Merge this cycle's LANES nibbles into the held word, MSB side first.
  always_comb begin
    sub_word = dout_q;
    box      = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      box = 3'(int'(cnt_q) * int'(LANES) + j);
      sub_word[31 - 4 * int'(box) -: 4] = sbox_lookup(box, sreg_q[47 - 6 * j -: 6]);
    end
  end

  assign last   = (cnt_q == CW'(N - 1));
  assign result = (PERM_EN && last && perm_q) ? p_perm(sub_word) : sub_word;

  assign o_in_ready  = (state_q == StIdle) || ((state_q == StHold) && i_out_ready);
  assign o_out_valid = out_valid_q;
  assign o_dout      = dout_q;
  assign o_busy      = busy_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sreg_q      <= '0;
      perm_q      <= 1'b0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_in_valid) begin
            sreg_q  <= i_din;
            perm_q  <= i_perm & PERM_EN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StSub;
          end
        end
        StSub: begin
          dout_q <= result;
          sreg_q <= sreg_q << SW;
          cnt_q  <= cnt_q + 1'b1;
          if (last) begin
            out_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (i_out_ready) begin
            out_valid_q <= 1'b0;
            // Retire and accept on the same edge keeps back-to-back words bubble-free.
            if (i_in_valid) begin
              sreg_q  <= i_din;
              perm_q  <= i_perm & PERM_EN;
              cnt_q   <= '0;
              state_q <= StSub;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_sbox_engine.sv
// Bench for des_sbox_engine: five instances (LANES 1/2/4/8, plus LANES=2 without P)
// checked against directed vectors and a software DES S+P model.
module tb_des_sbox_engine;

  localparam int NI = 5;
  localparam int unsigned LANES_TAB [NI] = '{1, 2, 4, 8, 2};
  localparam bit [NI-1:0] PEN_TAB = 5'b01111;

  localparam int SB [8][4][16] = '{
    '{'{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
      '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
      '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
      '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}},
    '{'{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10},
      '{3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5},
      '{0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15},
      '{13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9}},
    '{'{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8},
      '{13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1},
      '{13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7},
      '{1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12}},
    '{'{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15},
      '{13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9},
      '{10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4},
      '{3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14}},
    '{'{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9},
      '{14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6},
      '{4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14},
      '{11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3}},
    '{'{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11},
      '{10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8},
      '{9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6},
      '{4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13}},
    '{'{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1},
      '{13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6},
      '{1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2},
      '{6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12}},
    '{'{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7},
      '{1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2},
      '{7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8},
      '{2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}}
  };

  localparam int PT [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] in_valid  = '0;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] perm      = '0;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] out_ready = '0;
  logic [NI-1:0] busy;
  logic [47:0]   din  [NI];
  logic [31:0]   dout [NI];

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    des_sbox_engine #(
      .LANES  (LANES_TAB[g]),
      .PERM_EN(PEN_TAB[g])
    ) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_in_valid (in_valid[g]),
      .o_in_ready (in_ready[g]),
      .i_din      (din[g]),
      .i_perm     (perm[g]),
      .o_out_valid(out_valid[g]),
      .i_out_ready(out_ready[g]),
      .o_dout     (dout[g]),
      .o_busy     (busy[g])
    );
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [47:0] x, input bit p);
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  b;
    s = '0;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      b = x[47 - 6 * i -: 6];
      s[31 - 4 * i -: 4] = 4'(SB[i][{b[5], b[0]}][b[4:1]]);
    end
    if (!p) return s;
    for (int k = 0; k < 32; k++) y[31 - k] = s[32 - PT[k]];
    return y;
  endfunction

  task automatic wait_out(input int k, output int c);
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!out_valid[k] && c < 20);
  endtask

  typedef struct {
    int          inst;
    logic [47:0] din;
    bit          perm;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int k;
    int c;
    k = v.inst;
    @(posedge clk); #1;
    chk($sformatf("idle_ready[%0d]", k), 48'(in_ready[k]), 48'd1);
    in_valid[k]  = 1'b1;
    din[k]       = v.din;
    perm[k]      = v.perm;
    out_ready[k] = 1'b0;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    chk($sformatf("sub_ready[%0d]", k), 48'(in_ready[k]), 48'd0);
    chk($sformatf("sub_busy[%0d]", k), 48'(busy[k]), 48'd1);
    wait_out(k, c);
    chk($sformatf("latency[%0d] din=%0h", k, v.din), 48'(c), 48'(v.lat));
    chk($sformatf("dout[%0d] din=%0h perm=%0b", k, v.din, v.perm), 48'(dout[k]), 48'(v.exp));
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk($sformatf("retire_valid[%0d]", k), 48'(out_valid[k]), 48'd0);
    chk($sformatf("retire_busy[%0d]", k), 48'(busy[k]), 48'd0);
  endtask

  task automatic run_rand(input int k, input int count);
    logic [31:0] q [$];
    int sent;
    int got;
    int cyc;
    bit hs_in;
    bit hs_out;
    sent = 0; got = 0; cyc = 0; hs_in = 0; hs_out = 0;
    in_valid[k] = 1'b0;
    while (got < count && cyc < count * 30 + 200) begin
      @(posedge clk); #1;
      cyc++;
      if (hs_in) in_valid[k] = 1'b0;
      if (!in_valid[k] && sent < count && $urandom_range(0, 2) != 0) begin
        in_valid[k] = 1'b1;
        din[k]      = {16'($urandom), 32'($urandom)};
        perm[k]     = 1'($urandom_range(0, 1));
      end
      out_ready[k] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hs_in  = in_valid[k] && in_ready[k];
      hs_out = out_valid[k] && out_ready[k];
      if (hs_out) begin
        if (q.size() == 0) begin
          check_cnt++;
          $display("FAIL rand_spurious[%0d]: got %0h, expected no output", k, dout[k]);
        end else begin
          chk($sformatf("rand_dout[%0d] #%0d", k, got), 48'(dout[k]), 48'(q.pop_front()));
        end
        got++;
      end
      if (hs_in) begin
        q.push_back(model(din[k], perm[k] && PEN_TAB[k]));
        sent++;
      end
    end
    chk($sformatf("rand_count[%0d]", k), 48'(got), 48'(count));
    chk($sformatf("rand_leftover[%0d]", k), 48'(q.size()), 48'd0);
    @(posedge clk); #1;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
  endtask

  vec_t vecs [10];

  initial begin
    int c;
    vecs[0] = '{1, 48'h0,            1'b0, 32'hEFA72C4D, 4};
    vecs[1] = '{1, 48'hFFFFFFFFFFFF, 1'b0, 32'hD9CE3DCB, 4};
    vecs[2] = '{0, 48'hFFFFFFFFFFFF, 1'b0, 32'hD9CE3DCB, 8};
    vecs[3] = '{3, 48'hFFFFFFFFFFFF, 1'b0, 32'hD9CE3DCB, 1};
    vecs[4] = '{2, 48'h0,            1'b0, 32'hEFA72C4D, 2};
    vecs[5] = '{1, 48'h0,            1'b1, 32'hD8D8DBBC, 4};
    vecs[6] = '{4, 48'h0,            1'b1, 32'hEFA72C4D, 4};
    vecs[7] = '{0, 48'h0,            1'b1, 32'hD8D8DBBC, 8};
    vecs[8] = '{3, 48'h041041041041, 1'b0, 32'h03DDEAD1, 1};
    vecs[9] = '{1, 48'h820820820820, 1'b0, 32'h40DA4917, 4};

    for (int k = 0; k < NI; k++) din[k] = '0;
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_ready[%0d]", k), 48'(in_ready[k]), 48'd1);
      chk($sformatf("rst_valid[%0d]", k), 48'(out_valid[k]), 48'd0);
      chk($sformatf("rst_dout[%0d]", k), 48'(dout[k]), 48'd0);
      chk($sformatf("rst_busy[%0d]", k), 48'(busy[k]), 48'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    chk("model_p", 48'(model(48'h0, 1'b1)), 48'h00D8D8DBBC);

    // Back-pressure: result held while the next word waits upstream.
    @(posedge clk); #1;
    in_valid[1] = 1'b1; din[1] = '0; perm[1] = 1'b0; out_ready[1] = 1'b0;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    wait_out(1, c);
    chk("hold_first_latency", 48'(c), 48'd4);
    in_valid[1] = 1'b1;
    din[1]      = '1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_dout", 48'(dout[1]), 48'hEFA72C4D);
      chk("hold_ready", 48'(in_ready[1]), 48'd0);
      chk("hold_valid", 48'(out_valid[1]), 48'd1);
    end
    out_ready[1] = 1'b1;
    #1;
    chk("hold_passthru", 48'(in_ready[1]), 48'd1);
    @(posedge clk); #1;
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b0;
    chk("b2b_valid_drop", 48'(out_valid[1]), 48'd0);
    chk("b2b_busy", 48'(busy[1]), 48'd1);
    wait_out(1, c);
    chk("b2b_latency", 48'(c), 48'd4);
    chk("b2b_dout", 48'(dout[1]), 48'hD9CE3DCB);
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;

    // Reset during the second SUB cycle.
    in_valid[1] = 1'b1; din[1] = '1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 48'(in_ready[1]), 48'd1);
    chk("midrst_valid", 48'(out_valid[1]), 48'd0);
    chk("midrst_dout", 48'(dout[1]), 48'd0);
    chk("midrst_busy", 48'(busy[1]), 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    run_rand(0, 200);
    run_rand(1, 300);
    run_rand(2, 200);
    run_rand(3, 200);
    run_rand(4, 100);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, check_cnt);
    $fatal(1);
  end

endmodule

// File: doc/des_sbox_engine.md
Name: des_sbox_engine

Overview:
- Parametrised DES S-box substitution engine covering all eight standard DES S-boxes (S1..S8).
- Takes the 48-bit expanded, key-mixed round value and produces the 32-bit substituted word, optionally passed through the DES P permutation.
- Evaluates LANES S-boxes per cycle, time-multiplexed, so area trades against latency.
- Sits between the key-mix XOR and the L/R swap of the round datapath in the IOT data-filtering crypto path.

Parameters:
- LANES, 2, S-boxes evaluated per cycle; legal values 1, 2, 4, 8. Define N = 8/LANES.
- PERM_EN, 1, 1 = apply DES P permutation to the final word when i_perm=1; 0 = P logic absent and i_perm ignored.

Ports:
- i_clk, input, 1, clock, rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_in_valid, input, 1, input word valid.
- o_in_ready, output, 1, engine can accept an input word.
- i_din, input, 48, substitution input; bits [47:42] feed S1, ..., bits [5:0] feed S8.
- i_perm, input, 1, sampled with i_din; selects P permutation for this word.
- o_out_valid, output, 1, o_dout holds a result.
- i_out_ready, input, 1, downstream accepts the result.
- o_dout, output, 32, result; S1 nibble at [31:28], ..., S8 nibble at [3:0] (before P).
- o_busy, output, 1, high in SUB or HOLD.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; o_in_ready=1; o_out_valid=0; o_dout=0; o_busy=0; lane counter=0; input shift register=0. Reset asserted mid-operation discards the word in flight; no partial output is ever presented.
- S-box addressing, per 6-bit chunk b[5:0]: row={b5,b0}, col=b[4:1]. Tables are the standard FIPS 46-3 S1..S8, for example S1 row0 col0 = 14.
- FSM:
  - IDLE: o_in_ready=1. On i_in_valid && o_in_ready, latch i_din and i_perm, clear the counter, go to SUB.
  - SUB: each cycle, take the top LANES*6 bits of the shift register, write LANES nibbles into the result register at nibble index counter*LANES onward (from the MSB side), shift left by LANES*6, and increment the counter. When counter==N-1, go to HOLD.
    - The final result register write applies P if i_perm && PERM_EN.
    - P: output bit k (1 = MSB) takes input bit P[k], with P = 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25.
  - HOLD: o_out_valid=1 and o_dout is stable. o_in_ready = i_out_ready (combinational pass-through).
    - i_out_ready=1 with i_in_valid=1: result retired and new word latched on the same edge, go to SUB (back-to-back, no bubble).
    - i_out_ready=1 with i_in_valid=0: go to IDLE.
    - i_out_ready=0: stay in HOLD indefinitely; o_dout and o_out_valid must not change.
- Latency: handshake at edge T gives o_out_valid high after edge T+N. Throughput is one word per N cycles under continuous ready.
- i_in_valid while in SUB: o_in_ready=0, input ignored; the upstream side must hold.
- o_dout is updated only in SUB; in IDLE it retains the last result. o_out_valid is 0 in IDLE and SUB.
- The engine never drops a result; back-pressure is absorbed by HOLD.

Test Plan:
- LANES=2, i_din=48'h0, i_perm=0 -> o_out_valid rises 4 cycles after accept; o_dout=32'hEFA72C4D.
- LANES=2, i_din=48'hFFFFFFFFFFFF, i_perm=0 -> o_dout=32'hD9CE3DCB; repeat with LANES=1 (8-cycle latency) and LANES=8 (1-cycle latency), same value.
- i_din=48'h0, i_perm=1 -> o_dout = P(32'hEFA72C4D), checked against the reference model. With PERM_EN=0 -> 32'hEFA72C4D regardless of i_perm.
- Hold i_out_ready=0 for 10 cycles in HOLD while i_in_valid=1 -> o_dout stable, o_in_ready=0. Then raise i_out_ready -> old result retires and the new word is accepted on the same edge; the next result follows N cycles later.
- Assert i_rst_n=0 in the 2nd SUB cycle -> all outputs at reset values immediately. After release, an all-zero input yields 32'hEFA72C4D with no residue.
- Random 1000 words with random valid/ready gaps, all LANES values -> every output matches the software DES S+P model, in order, with no loss or duplication.
